hazard_control: RTL and testbench
=================================

// Module: hazard_control
// PURPOSE
//  Pipeline stall/flush controller: the hold/bubble counterpart of operand forwarding. Forwarding covers
//  every RAW case except load-use, branch-in-ID operands and data-memory wait. This block handles those.
//  Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC, and drives their write-enable/flush
//  controls. Also keeps stall and flush performance counters and a data-memory timeout flag.
// PARAMETERS
//  CNT_W        32   width of stall_cycles / flush_count counters (saturating)
//  MEM_TIMEOUT  64   MEM_WAIT cycles before mem_timeout is raised (>=2)
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous, active-low reset
//  ID_RegRs       in   5      rs of instruction in ID
//  ID_RegRt       in   5      rt of instruction in ID
//  ID_UsesRt      in   1      ID instruction reads rt (R-type, store, branch)
//  ID_Branch      in   1      ID holds beq/bne; compare is resolved in ID
//  ID_BranchTaken in   1      ID branch compare result (valid only when no stall is pending)
//  ID_Jump        in   1      ID holds j/jal/jr
//  EX_MemRead     in   1      EX holds a load
//  EX_RegWrite    in   1      EX instruction writes a register
//  EX_RegWrAddr   in   5      EX destination register
//  MEM_MemRead    in   1      MEM holds a load
//  MEM_RegWrAddr  in   5      MEM destination register
//  MEM_MemReq     in   1      MEM issues a data-memory access this cycle
//  MEM_MemReady   in   1      data memory completes access (same-cycle ready allowed)
//  PC_Write       out  1      PC update enable
//  IF_ID_Write    out  1      IF/ID hold when 0
//  IF_ID_Flush    out  1      IF/ID loaded with nop
//  ID_EX_Flush    out  1      ID/EX loaded with bubble (all control 0)
//  EX_MEM_Write   out  1      EX/MEM hold when 0
//  MEM_WB_Bubble  out  1      MEM/WB loaded with bubble
//  mem_timeout    out  1      sticky: MEM_WAIT exceeded MEM_TIMEOUT cycles
//  stall_cycles   out  CNT_W  cycles with PC_Write==0
//  flush_count    out  CNT_W  count of IF_ID_Flush assertions
// BEHAVIOUR
//  Reset (async, rst_n=0): state=RUN, counters=0, mem_timeout=0. Enables (PC_Write, IF_ID_Write,
//   EX_MEM_Write)=1, flushes/bubble=0. Outputs are combinational from state+inputs.
//  Hazard terms (register 0 never hazards):
//   lu   = EX_MemRead && EX_RegWrAddr!=0 && (ID_RegRs==EX_RegWrAddr || ID_UsesRt && ID_RegRt==EX_RegWrAddr)
//   brEX = ID_Branch && EX_RegWrite && EX_RegWrAddr!=0 && rs/rt match EX_RegWrAddr
//   brMM = ID_Branch && MEM_MemRead && MEM_RegWrAddr!=0 && rs/rt match MEM_RegWrAddr
//   stall = lu | brEX | brMM. A load followed by a branch stalls 2 cycles: brEX, then brMM.
//  FSM states: RUN, MEM_WAIT.
//   RUN: if MEM_MemReq && !MEM_MemReady -> MEM_WAIT. Otherwise stall -> PC_Write=0, IF_ID_Write=0,
//    ID_EX_Flush=1. Else if (ID_Branch&&ID_BranchTaken) | ID_Jump -> IF_ID_Flush=1.
//   MEM_WAIT: PC_Write=IF_ID_Write=EX_MEM_Write=0, MEM_WB_Bubble=1. No flush, and stall is not applied.
//    Wait counter increments each cycle. MEM_MemReady=1 -> RUN next cycle, and outputs are RUN values that
//    same cycle. Wait counter==MEM_TIMEOUT-1 -> mem_timeout<=1 (sticky until reset); state stays MEM_WAIT.
//  Priority: MEM wait > stall > branch/jump flush. A branch is never taken while stall is active.
//  The RUN-entry cycle (MEM_MemReq&&!MEM_MemReady) already drives the MEM_WAIT outputs. Freeze is immediate.
//  Counters: stall_cycles +1 per cycle with PC_Write==0. flush_count +1 per cycle with IF_ID_Flush==1.
//   Both saturate at all-ones and do not wrap.
//  Reset mid-wait: returns to RUN immediately. Wait counter cleared. Pending access is abandoned.
// STRUCTURE
//  Shared package/header: state encodings HC_RUN=1'b0, HC_MEM_WAIT=1'b1, REG_ZERO=5'd0.
//  One sub-module: hc_sat_counter (CNT_W, inc) -> count, saturating, async active-low clear.
//  Instantiated twice. Hazard compare and FSM stay in hazard_control.
// TESTING
//  1 lw $8 in EX, ID add $9,$8,$2 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cycles=1.
//  2 lw $8 in EX, ID beq $8,$0 -> two consecutive stall cycles (brEX then brMM), then branch resolves;
//    taken -> IF_ID_Flush=1 for 1 cycle, flush_count=1.
//  3 EX_RegWrAddr=0, EX_MemRead=1, ID_RegRs=0 -> no stall; all enables 1.
//  4 MEM_MemReq=1, MEM_MemReady low 3 cycles -> 3 frozen cycles with MEM_WB_Bubble=1; ready on cycle 4
//    -> RUN; stall_cycles=3.
//  5 MEM_TIMEOUT=4, ready never asserts -> mem_timeout=1 after 4th wait cycle, stays 1; rst_n low -> 0.
//  6 Force stall_cycles to 2^CNT_W-2 (CNT_W=4), stall 3 cycles -> holds 4'hF.

Source files
------------

// File: rtl/hazard_control_pkg.sv
// hazard_control_pkg: shared state encoding, zero-register constant and register-match helper
package hazard_control_pkg;
    typedef enum logic {HC_RUN = 1'b0, HC_MEM_WAIT = 1'b1} hc_state_e;
    localparam logic [4:0] REG_ZERO = 5'd0;
    // True when a non-zero destination rd is read as rs, or as rt when rt is used
    function automatic logic reg_hit(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                                     input logic [4:0] rd);
        return rd != REG_ZERO && (rs == rd || (use_rt && rt == rd));
    endfunction
endpackage

// File: rtl/hc_sat_counter.sv
// hc_sat_counter: saturating up-counter with asynchronous active-low clear
// Ports: clk, rst_n (async clear), inc (count enable), count (holds at all-ones)
module hc_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/hazard_control.sv
// hazard_control: pipeline stall/flush controller for load-use, branch-in-ID and data-memory wait hazards
// Ports: clk, rst_n (async active-low); ID_*/EX_*/MEM_* hazard sources from the pipeline registers;
//        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble pipeline controls;
//        mem_timeout (sticky), stall_cycles and flush_count (saturating performance counters)
module hazard_control
    import hazard_control_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_RegRs,
    input  logic [4:0]       ID_RegRt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_BranchTaken,
    input  logic             ID_Jump,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_RegWrAddr,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_RegWrAddr,
    input  logic             MEM_MemReq,
    input  logic             MEM_MemReady,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    hc_state_e         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu, br_ex, br_mm, stall, freeze;
    assign lu    = EX_MemRead && reg_hit(ID_RegRs, ID_RegRt, ID_UsesRt, EX_RegWrAddr);
    // Branches compare both operands in ID, so rt always counts for them
    assign br_ex = ID_Branch && EX_RegWrite && reg_hit(ID_RegRs, ID_RegRt, 1'b1, EX_RegWrAddr);
    assign br_mm = ID_Branch && MEM_MemRead && reg_hit(ID_RegRs, ID_RegRt, 1'b1, MEM_RegWrAddr);
    assign stall = lu || br_ex || br_mm;
    // Freeze starts on the request cycle itself and ends in the cycle ready arrives
    assign freeze = (state == HC_RUN) ? (MEM_MemReq && !MEM_MemReady) : !MEM_MemReady;
    assign PC_Write      = !(freeze || stall);
    assign IF_ID_Write   = !(freeze || stall);
    assign ID_EX_Flush   = !freeze && stall;
    assign IF_ID_Flush   = !freeze && !stall && ((ID_Branch && ID_BranchTaken) || ID_Jump);
    assign EX_MEM_Write  = !freeze;
    assign MEM_WB_Bubble = freeze;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HC_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (state == HC_RUN) begin
            if (freeze) begin
                state    <= HC_MEM_WAIT;
                wait_cnt <= '0;
            end
        end else if (MEM_MemReady) begin
            state <= HC_RUN;
        end else if (wait_cnt == WAIT_LAST) begin
            mem_timeout <= 1'b1;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
    hc_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .inc(!PC_Write), .count(stall_cycles)
    );
    hc_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .inc(IF_ID_Flush), .count(flush_count)
    );
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed plus randomized check of hazard_control against a behavioural model
module tb_hazard_control;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst_n;
    logic [4:0] ID_RegRs, ID_RegRt, EX_RegWrAddr, MEM_RegWrAddr;
    logic       ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump, EX_MemRead, EX_RegWrite;
    logic       MEM_MemRead, MEM_MemReq, MEM_MemReady;
    logic       pc_a, ifw_a, iff_a, idf_a, exw_a, wbb_a, to_a;
    logic       pc_b, ifw_b, iff_b, idf_b, exw_b, wbb_b, to_b;
    logic [31:0] sc_a, fc_a;
    logic [3:0]  sc_b, fc_b;
    hazard_control dut (
        .clk(clk), .rst_n(rst_n), .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_RegWrAddr(EX_RegWrAddr),
        .MEM_MemRead(MEM_MemRead), .MEM_RegWrAddr(MEM_RegWrAddr), .MEM_MemReq(MEM_MemReq),
        .MEM_MemReady(MEM_MemReady), .PC_Write(pc_a), .IF_ID_Write(ifw_a), .IF_ID_Flush(iff_a),
        .ID_EX_Flush(idf_a), .EX_MEM_Write(exw_a), .MEM_WB_Bubble(wbb_a), .mem_timeout(to_a),
        .stall_cycles(sc_a), .flush_count(fc_a)
    );
    hazard_control #(.CNT_W(4), .MEM_TIMEOUT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_RegWrAddr(EX_RegWrAddr),
        .MEM_MemRead(MEM_MemRead), .MEM_RegWrAddr(MEM_RegWrAddr), .MEM_MemReq(MEM_MemReq),
        .MEM_MemReady(MEM_MemReady), .PC_Write(pc_b), .IF_ID_Write(ifw_b), .IF_ID_Flush(iff_b),
        .ID_EX_Flush(idf_b), .EX_MEM_Write(exw_b), .MEM_WB_Bubble(wbb_b), .mem_timeout(to_b),
        .stall_cycles(sc_b), .flush_count(fc_b)
    );
    int n_chk = 0, n_fail = 0;
    // model state: waiting for memory, cycles spent waiting, sticky timeouts, counters
    bit     m_wait;
    int     m_wlen;
    bit     m_to_a, m_to_b;
    longint m_sc_a, m_fc_a, m_sc_b, m_fc_b;
    logic [5:0] last_ctl;
    localparam logic [5:0] CTL_RUN = 6'b110010, CTL_STALL = 6'b000110;
    localparam logic [5:0] CTL_FLUSH = 6'b111010, CTL_FREEZE = 6'b000001;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        {ID_RegRs, ID_RegRt, EX_RegWrAddr, MEM_RegWrAddr} = '0;
        {ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump, EX_MemRead, EX_RegWrite} = '0;
        {MEM_MemRead, MEM_MemReq, MEM_MemReady} = '0;
    endtask

    function automatic bit reads(input logic [4:0] rd, input bit use_rt);
        return rd != 0 && (ID_RegRs == rd || (use_rt && ID_RegRt == rd));
    endfunction

    function automatic longint sat_inc(input longint v, input bit inc, input longint max);
        return (inc && v < max) ? v + 1 : v;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_to"}, to_a, m_to_a);
        chk({tag, "_to4"}, to_b, m_to_b);
        chk({tag, "_sc"}, sc_a, m_sc_a);
        chk({tag, "_fc"}, fc_a, m_fc_a);
        chk({tag, "_sc4"}, sc_b, m_sc_b);
        chk({tag, "_fc4"}, fc_b, m_fc_b);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        m_wait = 0; m_wlen = 0; m_to_a = 0; m_to_b = 0;
        m_sc_a = 0; m_fc_a = 0; m_sc_b = 0; m_fc_b = 0;
        check_regs("rst");
        chk("rst_ctl", {pc_a, ifw_a, iff_a, idf_a, exw_a, wbb_a}, CTL_RUN);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step();
        bit stall, freeze, flush, halt;
        logic [5:0] exp;
        @(negedge clk);
        stall  = (EX_MemRead && reads(EX_RegWrAddr, ID_UsesRt)) ||
                 (ID_Branch && EX_RegWrite && reads(EX_RegWrAddr, 1)) ||
                 (ID_Branch && MEM_MemRead && reads(MEM_RegWrAddr, 1));
        freeze = m_wait ? !MEM_MemReady : (MEM_MemReq && !MEM_MemReady);
        flush  = ((ID_Branch && ID_BranchTaken) || ID_Jump);
        exp    = freeze ? CTL_FREEZE : stall ? CTL_STALL : flush ? CTL_FLUSH : CTL_RUN;
        last_ctl = {pc_a, ifw_a, iff_a, idf_a, exw_a, wbb_a};
        chk("ctl", last_ctl, exp);
        chk("ctl4", {pc_b, ifw_b, iff_b, idf_b, exw_b, wbb_b}, exp);
        check_regs("cyc");
        halt = exp[5] == 1'b0;
        m_sc_a = sat_inc(m_sc_a, halt, 64'hFFFF_FFFF);
        m_sc_b = sat_inc(m_sc_b, halt, 15);
        m_fc_a = sat_inc(m_fc_a, exp[3], 64'hFFFF_FFFF);
        m_fc_b = sat_inc(m_fc_b, exp[3], 15);
        if (m_wait) begin
            if (MEM_MemReady) m_wait = 0;
            else begin
                if (m_wlen >= 63) m_to_a = 1;
                if (m_wlen >= 3) m_to_b = 1;
                m_wlen++;
            end
        end else if (freeze) begin
            m_wait = 1;
            m_wlen = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        #1;
        do_reset();
        // load-use on rs
        EX_MemRead = 1; EX_RegWrite = 1; EX_RegWrAddr = 8; ID_RegRs = 8; ID_RegRt = 2; ID_UsesRt = 1;
        step();
        chk("t1_ctl", last_ctl, CTL_STALL);
        idle();
        step();
        chk("t1_sc", sc_a, 1);
        // load then branch: two stalls, then taken flush
        do_reset();
        EX_MemRead = 1; EX_RegWrite = 1; EX_RegWrAddr = 8;
        ID_Branch = 1; ID_BranchTaken = 1; ID_RegRs = 8; ID_UsesRt = 1;
        step();
        chk("t2_c1", last_ctl, CTL_STALL);
        EX_MemRead = 0; EX_RegWrite = 0; EX_RegWrAddr = 0; MEM_MemRead = 1; MEM_RegWrAddr = 8;
        step();
        chk("t2_c2", last_ctl, CTL_STALL);
        MEM_MemRead = 0; MEM_RegWrAddr = 0;
        step();
        chk("t2_c3", last_ctl, CTL_FLUSH);
        idle();
        step();
        chk("t2_fc", fc_a, 1);
        chk("t2_sc", sc_a, 2);
        // register zero never hazards
        do_reset();
        EX_MemRead = 1; EX_RegWrite = 1;
        step();
        chk("t3_ctl", last_ctl, CTL_RUN);
        // memory wait of three cycles
        do_reset();
        MEM_MemReq = 1;
        repeat (3) begin
            step();
            chk("t4_frz", last_ctl, CTL_FREEZE);
        end
        MEM_MemReady = 1;
        step();
        chk("t4_rel", last_ctl, CTL_RUN);
        chk("t4_sc", sc_a, 3);
        // timeout on the MEM_TIMEOUT=4 instance
        do_reset();
        MEM_MemReq = 1;
        repeat (4) step();
        chk("t5_pre", to_b, 0);
        step();
        chk("t5_set", to_b, 1);
        repeat (3) step();
        chk("t5_hold", to_b, 1);
        do_reset();
        // stall counter saturation on the 4-bit instance
        EX_MemRead = 1; EX_RegWrAddr = 8; ID_RegRs = 8;
        repeat (14) step();
        chk("t6_e", sc_b, 4'hE);
        repeat (3) step();
        chk("t6_f", sc_b, 4'hF);
        // randomized traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            ID_RegRs       = 5'($urandom_range(0, 3));
            ID_RegRt       = 5'($urandom_range(0, 3));
            EX_RegWrAddr   = 5'($urandom_range(0, 3));
            MEM_RegWrAddr  = 5'($urandom_range(0, 3));
            ID_UsesRt      = 1'($urandom);
            ID_Branch      = 1'($urandom);
            ID_BranchTaken = 1'($urandom);
            ID_Jump        = $urandom_range(0, 5) == 0;
            EX_MemRead     = 1'($urandom);
            EX_RegWrite    = 1'($urandom);
            MEM_MemRead    = 1'($urandom);
            MEM_MemReq     = $urandom_range(0, 3) == 0;
            MEM_MemReady   = $urandom_range(0, 2) == 0;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
